// File: rtl/clk_gate_pkg.sv
// Shared types and defaults for the capture-clock gate controller.
// Holds the FSM state encoding and the fixed-priority select helper.
package clk_gate_pkg;

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_WAKE = 2'd1,
    S_ON   = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam int unsigned DEF_N_REQ    = 3;
  localparam int unsigned DEF_WAKE_CYC = 2;
  localparam int unsigned DEF_HOLD_W   = 8;
  localparam int unsigned DEF_CNT_W    = 16;
  localparam int unsigned MAX_REQ      = 32;
  localparam int unsigned WAKE_CNT_W   = 4;

  // Index of the lowest set bit; MAX_REQ when no bit is set.
  function automatic int unsigned lowest_set_idx(input logic [MAX_REQ-1:0] v);
    int unsigned idx;
    idx = MAX_REQ;
    for (int unsigned i = MAX_REQ; i > 0; i--) begin
      if (v[i-1]) idx = i - 1;
    end
    return idx;
  endfunction

endpackage

// File: rtl/clk_gate_ctrl_if.sv
// Request/gate signal bundle between requesters and the gate controller.
interface clk_gate_ctrl_if
  import clk_gate_pkg::*;
#(
  parameter int unsigned N_REQ  = DEF_N_REQ,
  parameter int unsigned HOLD_W = DEF_HOLD_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) ();

  logic [N_REQ-1:0]  req;
  logic              busy;
  logic              force_on;
  logic [HOLD_W-1:0] hold_cyc;
  logic              gate;
  logic              ready;
  logic [N_REQ-1:0]  ack;
  logic [CNT_W-1:0]  on_count;
  logic [1:0]        state_o;

  modport master (
    output req, busy, force_on, hold_cyc,
    input  gate, ready, ack, on_count, state_o
  );

  modport slave (
    input  req, busy, force_on, hold_cyc,
    output gate, ready, ack, on_count, state_o
  );

endinterface

// File: rtl/req_arbiter.sv
// Fixed-priority one-hot acknowledge; each requester is served once per
// assertion and becomes eligible again only after its request drops.
module req_arbiter
  import clk_gate_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_enable,
  output logic [N_REQ-1:0] o_ack
);

  logic [N_REQ-1:0]   r_served;
  logic [MAX_REQ-1:0] w_pend;
  logic [N_REQ-1:0]   w_ack;
  int unsigned        w_idx;

  always_comb begin
    w_pend             = '0;
    w_pend[N_REQ-1:0]  = i_req & ~r_served;
    w_idx              = lowest_set_idx(w_pend);
    w_ack              = '0;
    if (i_enable) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (w_idx == i) w_ack[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_served <= '0;
    else     r_served <= (r_served | w_ack) & i_req;
  end

  assign o_ack = w_ack;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Gate controller for the capture clock: wakes on activity, settles for
// WAKE_CYC cycles, serves requests, and holds the gate for a tail before off.
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int unsigned N_REQ    = DEF_N_REQ,
  parameter int unsigned WAKE_CYC = DEF_WAKE_CYC,
  parameter int unsigned HOLD_W   = DEF_HOLD_W,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input logic           clk,
  input logic           rst,
  clk_gate_ctrl_if.slave cg
);

  state_t                r_state, w_state_nxt;
  logic [WAKE_CNT_W-1:0] r_wake_cnt, w_wake_nxt;
  logic [HOLD_W-1:0]     r_hold_cnt, w_hold_nxt;
  logic [CNT_W-1:0]      r_on_count, w_on_count_nxt;
  logic                  r_gate, w_gate_nxt;
  logic                  r_ready, w_ready_nxt;
  logic                  w_any_act;

  assign w_any_act = (|cg.req) | cg.busy | cg.force_on;

  always_comb begin
    w_state_nxt    = r_state;
    w_wake_nxt     = r_wake_cnt;
    w_hold_nxt     = r_hold_cnt;
    w_on_count_nxt = r_on_count;
    case (r_state)
      S_OFF: begin
        if (w_any_act) begin
          w_state_nxt    = S_WAKE;
          w_wake_nxt     = WAKE_CNT_W'(WAKE_CYC - 1);
          w_on_count_nxt = r_on_count + 1'b1;
        end
      end
      S_WAKE: begin
        if (r_wake_cnt == '0) w_state_nxt = S_ON;
        else                  w_wake_nxt  = r_wake_cnt - 1'b1;
      end
      S_ON: begin
        if (!w_any_act) begin
          w_state_nxt = S_HOLD;
          w_hold_nxt  = cg.hold_cyc;
        end
      end
      S_HOLD: begin
        if (w_any_act)              w_state_nxt = S_ON;
        else if (r_hold_cnt == '0)  w_state_nxt = S_OFF;
        else                        w_hold_nxt  = r_hold_cnt - 1'b1;
      end
      default: w_state_nxt = S_OFF;
    endcase
    // gate/ready are registered copies of the next state so they never glitch
    w_gate_nxt  = (w_state_nxt != S_OFF);
    w_ready_nxt = (w_state_nxt == S_ON) || (w_state_nxt == S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_OFF;
      r_wake_cnt <= '0;
      r_hold_cnt <= '0;
      r_on_count <= '0;
      r_gate     <= 1'b0;
      r_ready    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wake_cnt <= w_wake_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_on_count <= w_on_count_nxt;
      r_gate     <= w_gate_nxt;
      r_ready    <= w_ready_nxt;
    end
  end

  req_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_req    (cg.req),
    .i_enable (r_state == S_ON),
    .o_ack    (cg.ack)
  );

  assign cg.gate     = r_gate;
  assign cg.ready    = r_ready;
  assign cg.on_count = r_on_count;
  assign cg.state_o  = r_state;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl; a second 4-bit-counter instance shares
// the stimulus to exercise on_count wrap.
module tb_clk_gate_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errs   = 0;

  always #5 clk = ~clk;

  clk_gate_ctrl_if #(.N_REQ(3), .HOLD_W(8), .CNT_W(16)) cg ();
  clk_gate_ctrl_if #(.N_REQ(3), .HOLD_W(8), .CNT_W(4))  cg4 ();

  assign cg4.req      = cg.req;
  assign cg4.busy     = cg.busy;
  assign cg4.force_on = cg.force_on;
  assign cg4.hold_cyc = cg.hold_cyc;

  clk_gate_ctrl #(.N_REQ(3), .WAKE_CYC(2), .HOLD_W(8), .CNT_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .cg  (cg)
  );

  clk_gate_ctrl #(.N_REQ(3), .WAKE_CYC(2), .HOLD_W(8), .CNT_W(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .cg  (cg4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_off(input string tag);
    chk({tag, "_gate"},  32'(cg.gate),    32'd0);
    chk({tag, "_ready"}, 32'(cg.ready),   32'd0);
    chk({tag, "_state"}, 32'(cg.state_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    cg.req      = '0;
    cg.busy     = 1'b0;
    cg.force_on = 1'b0;
    cg.hold_cyc = 8'd4;
    repeat (3) tick();
    chk_off("rst");
    chk("rst_cnt", 32'(cg.on_count), 32'd0);
    chk("rst_ack", 32'(cg.ack), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      tick();
      chk_off("idle");
      chk("idle_cnt", 32'(cg.on_count), 32'd0);
    end

    // single requester wake and ack
    tick(); cg.req = 3'b001; #1;
    chk("pre_gate", 32'(cg.gate), 32'd0);
    tick();
    chk("wake_gate",  32'(cg.gate),     32'd1);
    chk("wake_ready", 32'(cg.ready),    32'd0);
    chk("wake_state", 32'(cg.state_o),  32'd1);
    chk("wake_cnt",   32'(cg.on_count), 32'd1);
    tick();
    chk("wake2_state", 32'(cg.state_o), 32'd1);
    chk("wake2_ready", 32'(cg.ready),   32'd0);
    tick();
    chk("on_ready", 32'(cg.ready),   32'd1);
    chk("on_state", 32'(cg.state_o), 32'd2);
    chk("on_ack0",  32'(cg.ack),     32'd1);
    tick(); chk("ack0_once", 32'(cg.ack), 32'd0);
    tick(); chk("ack0_held", 32'(cg.ack), 32'd0);

    // priority and re-arm
    tick(); cg.req = 3'b110; #1;
    chk("pri_ack1", 32'(cg.ack), 32'd2);
    tick(); chk("pri_ack2", 32'(cg.ack), 32'd4);
    tick(); chk("pri_none", 32'(cg.ack), 32'd0);
    tick(); cg.req = 3'b100; #1;
    chk("drop_ack", 32'(cg.ack), 32'd0);
    tick(); cg.req = 3'b110; #1;
    chk("rearm_ack1", 32'(cg.ack), 32'd2);
    tick(); chk("rearm_once", 32'(cg.ack), 32'd0);

    // hold tail of hold_cyc+1 cycles
    tick(); cg.req = 3'b000; #1;
    chk("hold_pre", 32'(cg.state_o), 32'd2);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_state", 32'(cg.state_o), 32'd3);
      chk("hold_gate",  32'(cg.gate),    32'd1);
      chk("hold_ready", 32'(cg.ready),   32'd1);
    end
    tick(); chk_off("hold_end");

    // reassert during HOLD returns to ON without re-wake
    tick(); cg.req = 3'b001; #1;
    tick(); chk("w2_cnt", 32'(cg.on_count), 32'd2);
    tick();
    tick(); chk("w2_ack", 32'(cg.ack), 32'd1);
    tick(); cg.req = 3'b000; #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("h2_state", 32'(cg.state_o), 32'd3);
    end
    cg.req = 3'b010; #1;
    chk("h2_noack", 32'(cg.ack), 32'd0);
    tick();
    chk("reon_state", 32'(cg.state_o),  32'd2);
    chk("reon_ready", 32'(cg.ready),    32'd1);
    chk("reon_cnt",   32'(cg.on_count), 32'd2);
    chk("reon_ack",   32'(cg.ack),      32'd2);
    tick(); cg.req = 3'b000; #1;
    repeat (6) tick();
    chk_off("h2_end");

    // force_on override
    tick(); cg.force_on = 1'b1; #1;
    tick();
    chk("f_gate", 32'(cg.gate),     32'd1);
    chk("f_cnt",  32'(cg.on_count), 32'd3);
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("f_hold_gate", 32'(cg.gate), 32'd1);
    end
    chk("f_state", 32'(cg.state_o), 32'd2);
    cg.force_on = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("f_tail_gate", 32'(cg.gate), 32'd1);
    end
    tick(); chk_off("f_end");

    // req and busy together = one wake; busy blocks gate-off; rst in ON
    tick(); cg.req = 3'b001; cg.busy = 1'b1; #1;
    tick(); chk("rb_cnt", 32'(cg.on_count), 32'd4);
    tick();
    tick(); chk("rb_ack", 32'(cg.ack), 32'd1);
    tick(); cg.req = 3'b000; #1;
    tick(); chk("busy_on1", 32'(cg.state_o), 32'd2);
    tick(); chk("busy_on2", 32'(cg.state_o), 32'd2);
    rst = 1'b1;
    tick();
    chk_off("rst_on");
    chk("rst_on_cnt", 32'(cg.on_count), 32'd0);
    chk("rst_on_ack", 32'(cg.ack),      32'd0);
    rst = 1'b0; cg.busy = 1'b0;

    // rst in WAKE
    tick(); cg.req = 3'b001; #1;
    tick(); chk("rw_state", 32'(cg.state_o), 32'd1);
    rst = 1'b1; cg.req = 3'b000;
    tick();
    chk_off("rst_wake");
    chk("rst_wake_cnt", 32'(cg.on_count), 32'd0);
    rst = 1'b0;
    tick(); chk("rw_idle", 32'(cg.state_o), 32'd0);

    // 16 short bursts with hold_cyc=0: single HOLD cycle, 4-bit counter wraps
    cg.hold_cyc = 8'd0;
    for (int b = 0; b < 16; b++) begin
      tick(); cg.req = 3'b100; #1;
      tick(); cg.req = 3'b000; #1;
      chk("b_wake", 32'(cg.state_o), 32'd1);
      tick(); chk("b_wake2", 32'(cg.state_o), 32'd1);
      tick(); chk("b_on",    32'(cg.state_o), 32'd2);
      tick(); chk("b_hold",  32'(cg.state_o), 32'd3);
      tick(); chk("b_off",   32'(cg.state_o), 32'd0);
      if (b == 14) chk("c4_15", 32'(cg4.on_count), 32'd15);
    end
    chk("c4_wrap", 32'(cg4.on_count), 32'd0);
    chk("c16_cnt", 32'(cg.on_count),  32'd16);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
